// File: rtl/eth_prbs31_checker.sv
// Receive-side PRBS31 (x^31+x^28+1) checker for 66-bit 10GBASE-R blocks.
// Self-synchronising: each bit is predicted from the raw received bits 28 and 31 positions earlier.
module eth_prbs31_checker #(
  parameter int DATA_WIDTH    = 64,
  parameter int HDR_WIDTH     = 2,
  parameter int COUNT_WIDTH   = 16,
  parameter int LOCK_BLOCKS   = 8,
  parameter int UNLOCK_BLOCKS = 4
) (
  input  logic                   rx_clk,
  input  logic                   rx_rst_n,
  input  logic                   cfg_enable,
  input  logic                   cfg_clear,
  input  logic                   serdes_rx_valid,
  input  logic [HDR_WIDTH-1:0]   serdes_rx_hdr,
  input  logic [DATA_WIDTH-1:0]  serdes_rx_data,
  output logic                   err_valid,
  output logic [6:0]             err_bits,
  output logic                   err_block,
  output logic [COUNT_WIDTH-1:0] err_count,
  output logic                   prbs_lock,
  output logic [1:0]             dbg_state
);

  localparam int BW = DATA_WIDTH + HDR_WIDTH;
  localparam int GW = $clog2(LOCK_BLOCKS + 1);
  localparam int UW = $clog2(UNLOCK_BLOCKS + 1);
  localparam int SW = ((COUNT_WIDTH > 7) ? COUNT_WIDTH : 7) + 1;
  localparam logic [SW-1:0] CMAX = {{(SW-COUNT_WIDTH){1'b0}}, {COUNT_WIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE = 2'd0, SEED = 2'd1, CHECK = 2'd2} state_t;

  state_t          state;
  logic [30:0]     s;
  logic [GW-1:0]   good_run;
  logic [UW-1:0]   bad_run;
  logic [BW-1:0]   v;
  logic [BW+30:0]  ext;
  logic [BW-1:0]   e;
  logic [6:0]      nerr;
  logic [GW-1:0]   g_next;
  logic [UW-1:0]   b_next;
  logic [SW-1:0]   cnt_base;
  logic [SW-1:0]   cnt_sum;

  assign dbg_state = state;
  assign v         = {serdes_rx_data, serdes_rx_hdr};
  // ext[0] is the oldest stored bit; rx bit n of this block sits at ext[n+31].
  assign ext       = {v, s};

  always_comb begin
    e    = '0;
    nerr = '0;
    for (int n = 0; n < BW; n++) begin
      e[n] = ext[n+31] ^ ext[n] ^ ext[n+3];
    end
    for (int n = 0; n < BW; n++) begin
      nerr = nerr + 7'(e[n]);
    end
  end

  assign g_next = (good_run == GW'(LOCK_BLOCKS))   ? good_run : good_run + GW'(1);
  assign b_next = (bad_run  == UW'(UNLOCK_BLOCKS)) ? bad_run  : bad_run  + UW'(1);

  // Blocks are accepted on every cycle with serdes_rx_valid=1; there is no backpressure.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state     <= IDLE;
      s         <= '0;
      good_run  <= '0;
      bad_run   <= '0;
      err_valid <= 1'b0;
      err_bits  <= '0;
      err_block <= 1'b0;
      prbs_lock <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      if (!cfg_enable) begin
        state     <= IDLE;
        prbs_lock <= 1'b0;
      end else if (serdes_rx_valid) begin
        s <= v[BW-1 -: 31];
        case (state)
          IDLE, SEED: begin
            state    <= CHECK;
            good_run <= '0;
            bad_run  <= '0;
          end
          CHECK: begin
            err_valid <= 1'b1;
            err_bits  <= nerr;
            err_block <= (nerr != 7'd0);
            if (nerr == 7'd0) begin
              good_run <= g_next;
              bad_run  <= '0;
              if (g_next == GW'(LOCK_BLOCKS)) prbs_lock <= 1'b1;
            end else begin
              good_run <= '0;
              if (prbs_lock && (b_next == UW'(UNLOCK_BLOCKS))) begin
                prbs_lock <= 1'b0;
                state     <= SEED;
                bad_run   <= '0;
              end else begin
                bad_run <= b_next;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        state <= SEED;
      end
    end
  end

  // Clear applies before the add so a clear coinciding with a result keeps that result.
  assign cnt_base = cfg_clear ? '0 : SW'(err_count);
  assign cnt_sum  = cnt_base + SW'(err_bits);

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      err_count <= '0;
    end else if (err_valid) begin
      err_count <= (cnt_sum > CMAX) ? {COUNT_WIDTH{1'b1}} : cnt_sum[COUNT_WIDTH-1:0];
    end else if (cfg_clear) begin
      err_count <= '0;
    end
  end

endmodule

// File: tb/tb_eth_prbs31_checker.sv
// Directed bench for eth_prbs31_checker: table of block vectors plus hand sequences.
// A second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_eth_prbs31_checker;

  localparam logic [1:0] K_CLEAN = 2'd0;
  localparam logic [1:0] K_FLIP  = 2'd1;
  localparam logic [1:0] K_INV   = 2'd2;

  logic        rx_clk = 1'b0;
  logic        rx_rst_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic        cfg_clear = 1'b0;
  logic        serdes_rx_valid = 1'b0;
  logic [1:0]  serdes_rx_hdr = '0;
  logic [63:0] serdes_rx_data = '0;

  logic        err_valid, err_block, prbs_lock;
  logic [6:0]  err_bits;
  logic [15:0] err_count;
  logic [1:0]  dbg_state;
  logic        err_valid4, err_block4, prbs_lock4;
  logic [6:0]  err_bits4;
  logic [3:0]  err_count4;
  logic [1:0]  dbg_state4;

  eth_prbs31_checker dut (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .cfg_enable(cfg_enable), .cfg_clear(cfg_clear),
    .serdes_rx_valid(serdes_rx_valid), .serdes_rx_hdr(serdes_rx_hdr), .serdes_rx_data(serdes_rx_data),
    .err_valid(err_valid), .err_bits(err_bits), .err_block(err_block), .err_count(err_count),
    .prbs_lock(prbs_lock), .dbg_state(dbg_state)
  );

  eth_prbs31_checker #(.COUNT_WIDTH(4)) dut4 (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .cfg_enable(cfg_enable), .cfg_clear(cfg_clear),
    .serdes_rx_valid(serdes_rx_valid), .serdes_rx_hdr(serdes_rx_hdr), .serdes_rx_data(serdes_rx_data),
    .err_valid(err_valid4), .err_bits(err_bits4), .err_block(err_block4), .err_count(err_count4),
    .prbs_lock(prbs_lock4), .dbg_state(dbg_state4)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic       en;
    logic       valid;
    logic [1:0] kind;
    logic       clear;
    logic       ev;
    logic [6:0] bits;
    logic       lock;
  } vec_t;

  vec_t        tbl[$];
  logic [30:0] hist = '1;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          exp16 = 0;
  int          exp4 = 0;
  logic        prev_ev = 1'b0;
  int          prev_bits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic en, input logic valid, input logic [1:0] kind,
                              input logic clear, input logic ev, input logic [6:0] bits,
                              input logic lock);
    vec_t t;
    t.en = en; t.valid = valid; t.kind = kind; t.clear = clear;
    t.ev = ev; t.bits = bits; t.lock = lock;
    tbl.push_back(t);
  endfunction

  // Serial PRBS31 generator: each new bit is r[n-31] ^ r[n-28].
  function automatic logic [65:0] next_block();
    logic [65:0] v;
    logic        b;
    for (int i = 0; i < 66; i++) begin
      b    = hist[0] ^ hist[3];
      v[i] = b;
      hist = {b, hist[30:1]};
    end
    return v;
  endfunction

  function automatic int upd(input int c, input logic clr, input int mx);
    int r;
    r = clr ? 0 : c;
    if (prev_ev) begin
      r = r + prev_bits;
      if (r > mx) r = mx;
    end
    return r;
  endfunction

  task automatic apply(input vec_t t, input int idx);
    logic [65:0] blk;
    cfg_enable      = t.en;
    cfg_clear       = t.clear;
    serdes_rx_valid = t.valid;
    if (t.valid) begin
      blk = next_block();
      if (t.kind == K_FLIP) blk[2] = ~blk[2];
      else if (t.kind == K_INV) blk = ~blk;
      serdes_rx_hdr  = blk[1:0];
      serdes_rx_data = blk[65:2];
    end else begin
      serdes_rx_hdr  = 2'($urandom);
      serdes_rx_data = {$urandom, $urandom};
    end
    @(posedge rx_clk);
    exp16     = upd(exp16, t.clear, 65535);
    exp4      = upd(exp4, t.clear, 15);
    prev_ev   = t.ev;
    prev_bits = int'(t.bits);
    @(negedge rx_clk);
    check($sformatf("row%0d err_valid", idx), 32'(err_valid), 32'(t.ev));
    if (t.ev) begin
      check($sformatf("row%0d err_bits", idx), 32'(err_bits), 32'(t.bits));
      check($sformatf("row%0d err_block", idx), 32'(err_block), 32'(t.bits != 7'd0));
    end
    check($sformatf("row%0d prbs_lock", idx), 32'(prbs_lock), 32'(t.lock));
    check($sformatf("row%0d err_count", idx), 32'(err_count), 32'(exp16));
    check($sformatf("row%0d err_count4", idx), 32'(err_count4), 32'(exp4));
  endtask

  int row_id = 0;

  task automatic run_rows();
    while (tbl.size() > 0) begin
      apply(tbl.pop_front(), row_id);
      row_id++;
    end
  endtask

  initial begin
    cfg_enable = 1'b1;
    repeat (2) @(negedge rx_clk);
    check("reset err_valid", 32'(err_valid), 32'd0);
    check("reset err_bits", 32'(err_bits), 32'd0);
    check("reset err_count", 32'(err_count), 32'd0);
    check("reset prbs_lock", 32'(prbs_lock), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    rx_rst_n = 1'b1;

    // Clean stream: first block seeds, lock with the 8th checked result.
    add(1, 1, K_CLEAN, 0, 0, 0, 0);
    for (int i = 1; i < 20; i++) add(1, 1, K_CLEAN, 0, 1, 0, i >= 8);
    // Single flipped line bit gives three error bits.
    add(1, 1, K_FLIP, 0, 1, 3, 1);
    add(1, 1, K_CLEAN, 0, 1, 0, 1);
    // Inverted blocks: 63 errors against a clean history, then 66; lock drops on the 4th.
    add(1, 1, K_INV, 0, 1, 63, 1);
    add(1, 1, K_INV, 0, 1, 66, 1);
    add(1, 1, K_INV, 0, 1, 66, 1);
    add(1, 1, K_INV, 0, 1, 66, 0);
    add(1, 1, K_CLEAN, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) add(1, 1, K_CLEAN, 0, 1, 0, i == 8);
    // Clear, then 18 error bits: the 4-bit counter stops at 15.
    add(1, 0, K_CLEAN, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      add(1, 1, K_FLIP, 0, 1, 3, 1);
      add(1, 1, K_CLEAN, 0, 1, 0, 1);
    end
    run_rows();
    check("sat err_count4", 32'(err_count4), 32'd15);
    check("sat err_count", 32'(err_count), 32'd18);

    // Clear coinciding with an err_bits=3 result.
    add(1, 1, K_FLIP, 0, 1, 3, 1);
    add(1, 1, K_CLEAN, 1, 1, 0, 1);
    // Disable drops lock; then sparse valid blocks, lock counts valid blocks only.
    add(0, 1, K_CLEAN, 0, 0, 0, 0);
    add(1, 1, K_CLEAN, 0, 0, 0, 0);
    for (int j = 1; j <= 8; j++) begin
      add(1, 0, K_CLEAN, 0, 0, 0, 0);
      add(1, 1, K_CLEAN, 0, 1, 0, j == 8);
    end
    add(1, 0, K_CLEAN, 0, 0, 0, 1);
    add(1, 1, K_CLEAN, 0, 1, 0, 1);
    run_rows();
    check("clear err_count", 32'(err_count), 32'd3);
    check("clear err_count4", 32'(err_count4), 32'd3);

    // Asynchronous reset in the middle of a cycle.
    serdes_rx_valid = 1'b1;
    {serdes_rx_data, serdes_rx_hdr} = next_block();
    @(posedge rx_clk);
    #3 rx_rst_n = 1'b0;
    #1;
    check("async err_valid", 32'(err_valid), 32'd0);
    check("async err_bits", 32'(err_bits), 32'd0);
    check("async err_block", 32'(err_block), 32'd0);
    check("async err_count", 32'(err_count), 32'd0);
    check("async err_count4", 32'(err_count4), 32'd0);
    check("async prbs_lock", 32'(prbs_lock), 32'd0);
    @(negedge rx_clk);
    rx_rst_n  = 1'b1;
    exp16     = 0;
    exp4      = 0;
    prev_ev   = 1'b0;
    prev_bits = 0;
    add(1, 1, K_CLEAN, 0, 0, 0, 0);
    add(1, 1, K_CLEAN, 0, 1, 0, 0);
    add(1, 1, K_FLIP, 0, 1, 3, 0);
    add(1, 1, K_CLEAN, 0, 1, 0, 0);
    run_rows();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
